ac_sequencer: RTL and testbench
===============================

// Module: ac_sequencer
// PURPOSE
//  Sequences the HVAC plant from the heating/cooling demand produced by the AC thermostat.
//  Enforces fan pre-run, minimum on-time, fan post-run and compressor lockout (anti-short-cycle).
//  Sits between the AC thermostat outputs and the plant enables (fan, heater, compressor).
// PARAMETERS
//  PRE_CYC   4   fan-only cycles before heater/compressor enable (>=1)
//  MIN_ON    16  minimum cycles heater/compressor stays enabled (>=1)
//  POST_CYC  8   fan-only cycles after heater/compressor disable (>=1)
//  LOCKOUT   32  all-off cycles after a cooling run before any new request (>=1)
//  CNT_W     8   dwell counter width; must hold max(parameter)-1
// PORTS
//  clk            in   1  system clock, rising edge
//  rst            in   1  synchronous active-high reset
//  heat_req       in   1  heating demand (AC heating output)
//  cool_req       in   1  cooling demand (AC cooling output)
//  fan            out  1  fan enable
//  heater_en      out  1  heater enable
//  compressor_en  out  1  compressor enable
//  conflict       out  1  1-cycle pulse: both requests high while IDLE
//  state          out  3  current state encoding (debug)
// BEHAVIOUR
//  - All outputs registered. On rst=1 at an edge: state=IDLE, counter=0, all outputs 0. Applies mid-run; no lockout after reset.
//  - States: IDLE=0, PRE=1, HEAT=2, COOL=3, POST=4, LOCK=5. 6,7 are illegal -> IDLE on next edge.
//  - IDLE: all outputs 0. heat_req^cool_req -> PRE, mode latched (heat/cool), cnt=PRE_CYC-1.
//    Both requests high -> stay IDLE, conflict=1 for that cycle. Neither high -> stay.
//  - PRE: fan=1. Latched request dropped -> POST, cnt=POST_CYC-1, no heater/compressor pulse.
//    Otherwise cnt decrements; at cnt==0 -> HEAT or COOL per mode, cnt=MIN_ON-1. PRE lasts exactly PRE_CYC cycles.
//  - HEAT: fan=1, heater_en=1. cnt decrements, saturates at 0. Exit when cnt==0 and (heat_req==0 or cool_req==1)
//    -> POST, cnt=POST_CYC-1. Request loss before cnt==0 is ignored (min on-time).
//  - COOL: same as HEAT with compressor_en; exit on cool_req==0 or heat_req==1.
//  - POST: fan=1 only; requests ignored. At cnt==0 -> LOCK (cnt=LOCKOUT-1) if mode=cool, else IDLE.
//  - LOCK: all outputs 0; requests ignored. At cnt==0 -> IDLE. Pending request is serviced from IDLE next cycle.
//  - Invariants: heater_en & compressor_en never both 1; heater_en or compressor_en implies fan; state changes only on posedge clk.
//  - Latency: request sampled in IDLE at edge N -> fan=1 after edge N; enable after edge N+PRE_CYC.
// STRUCTURE
//  - Shared package/header ac_pkg: state encodings (ST_IDLE..ST_LOCK) and the 3-bit state width constant.
//  - Sub-module dwell_timer: CNT_W down-counter; load/value inputs, saturating decrement, done = (cnt==0).
//  - Top: state register, next-state logic, registered output decode, conflict pulse.
// TESTING (defaults PRE=4, MIN_ON=16, POST=8, LOCKOUT=32)
//  1. Reset, then heat_req=1 held -> fan=1 next cycle; heater_en=1 after 4 more cycles; compressor_en stays 0.
//  2. In HEAT, drop heat_req 3 cycles in -> heater_en stays 1 for 16 cycles total, then fan-only 8 cycles, then IDLE (no LOCK).
//  3. cool_req 40 cycles then 0 -> COOL, POST 8, LOCK 32 all-off; cool_req re-raised mid-LOCK -> fan only after LOCK ends (IDLE, then PRE).
//  4. heat_req=cool_req=1 in IDLE -> conflict=1 each such cycle, state stays 0, all enables 0.
//  5. rst=1 while in COOL -> after that edge state=0, fan=heater_en=compressor_en=0; next request starts PRE immediately.
//  6. In HEAT after min-on, heat_req->0 and cool_req->1 same cycle -> POST 8, IDLE 1 cycle, PRE 4, COOL; enables never overlap.

Source files
------------

// File: rtl/ac_pkg.sv
// Shared definitions for the AC plant sequencer: state encodings and width.
package ac_pkg;

  localparam int STATE_W = 3;

  // Encodings are visible on the debug state port, so values are fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_HEAT = 3'd2,
    ST_COOL = 3'd3,
    ST_POST = 3'd4,
    ST_LOCK = 3'd5
  } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that measures how long the sequencer dwells in a state.
// Decrements every cycle it is not loaded and holds at zero.
module dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Load, or count down and saturate at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ac_sequencer.sv
// HVAC plant sequencer: turns thermostat heat/cool demand into fan, heater and
// compressor enables with fan pre-run, minimum on-time, fan post-run and a
// compressor lockout after every cooling run.
module ac_sequencer
  import ac_pkg::*;
#(
  parameter int PRE_CYC  = 4,
  parameter int MIN_ON   = 16,
  parameter int POST_CYC = 8,
  parameter int LOCKOUT  = 32,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               heat_req,
  input  logic               cool_req,
  output logic               fan,
  output logic               heater_en,
  output logic               compressor_en,
  output logic               conflict,
  output logic [STATE_W-1:0] state
);

  // Timer load values: a dwell of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_LD  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] POST_LD = CNT_W'(POST_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCKOUT - 1);

  state_t           state_q, state_d;
  logic             mode_cool_q, mode_cool_d;
  logic             conflict_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_done;

  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  // Next-state, mode latch, timer reload and conflict detection.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    mode_cool_d = mode_cool_q;
    conflict_d  = 1'b0;
    tmr_load    = 1'b0;
    tmr_value   = '0;
    case (state_q)
      ST_IDLE: begin
        if (heat_req ^ cool_req) begin
          state_d     = ST_PRE;
          mode_cool_d = cool_req;
          tmr_load    = 1'b1;
          tmr_value   = PRE_LD;
        end else if (heat_req && cool_req) begin
          conflict_d = 1'b1;
        end
      end
      ST_PRE: begin
        if (mode_cool_q ? !cool_req : !heat_req) begin
          // Demand vanished during pre-run: never pulse the heater/compressor.
          state_d   = ST_POST;
          tmr_load  = 1'b1;
          tmr_value = POST_LD;
        end else if (tmr_done) begin
          state_d   = mode_cool_q ? ST_COOL : ST_HEAT;
          tmr_load  = 1'b1;
          tmr_value = MIN_LD;
        end
      end
      ST_HEAT: begin
        if (tmr_done && (!heat_req || cool_req)) begin
          state_d   = ST_POST;
          tmr_load  = 1'b1;
          tmr_value = POST_LD;
        end
      end
      ST_COOL: begin
        if (tmr_done && (!cool_req || heat_req)) begin
          state_d   = ST_POST;
          tmr_load  = 1'b1;
          tmr_value = POST_LD;
        end
      end
      ST_POST: begin
        if (tmr_done) begin
          if (mode_cool_q) begin
            state_d   = ST_LOCK;
            tmr_load  = 1'b1;
            tmr_value = LOCK_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_LOCK: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register plus registered output decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mode_cool_q   <= 1'b0;
      fan           <= 1'b0;
      heater_en     <= 1'b0;
      compressor_en <= 1'b0;
      conflict      <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_cool_q   <= mode_cool_d;
      // NOTE: outputs decode the next state so they change on the same edge as state.
      fan           <= (state_d == ST_PRE) || (state_d == ST_HEAT) ||
                       (state_d == ST_COOL) || (state_d == ST_POST);
      heater_en     <= (state_d == ST_HEAT);
      compressor_en <= (state_d == ST_COOL);
      conflict      <= conflict_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ac_sequencer.sv
// Self-checking bench for ac_sequencer: directed stimulus, a phase/elapsed-time
// model compared every cycle, and literal expectations for each scenario.
module tb_ac_sequencer;

  localparam int PRE_CYC  = 4;
  localparam int MIN_ON   = 16;
  localparam int POST_CYC = 8;
  localparam int LOCKOUT  = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       heat_req;
  logic       cool_req;
  logic       fan;
  logic       heater_en;
  logic       compressor_en;
  logic       conflict;
  logic [2:0] state;

  int total_cnt = 0;
  int pass_cnt  = 0;

  ac_sequencer #(
    .PRE_CYC (PRE_CYC),
    .MIN_ON  (MIN_ON),
    .POST_CYC(POST_CYC),
    .LOCKOUT (LOCKOUT),
    .CNT_W   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .heat_req     (heat_req),
    .cool_req     (cool_req),
    .fan          (fan),
    .heater_en    (heater_en),
    .compressor_en(compressor_en),
    .conflict     (conflict),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else pass_cnt++;
  endtask

  // Model: a plant phase plus the number of cycles already spent in it.
  typedef enum {M_IDLE, M_PRE, M_RUN, M_POST, M_LOCK} mphase_t;
  mphase_t m_phase = M_IDLE;
  int      m_el    = 0;
  bit      m_cool  = 1'b0;
  bit      m_conf  = 1'b0;
  bit      m_valid = 1'b0;

  function automatic logic [2:0] m_code(input mphase_t p, input bit cool);
    case (p)
      M_IDLE:  return 3'd0;
      M_PRE:   return 3'd1;
      M_RUN:   return cool ? 3'd3 : 3'd2;
      M_POST:  return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  // Advance the model on every edge, then compare all outputs against it.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      m_phase = M_IDLE; m_el = 0; m_cool = 1'b0; m_conf = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_conf = 1'b0;
      case (m_phase)
        M_IDLE: begin
          if (heat_req ^ cool_req) begin
            m_phase = M_PRE; m_el = 1; m_cool = cool_req;
          end else if (heat_req && cool_req) begin
            m_conf = 1'b1;
          end
        end
        M_PRE: begin
          if (!(m_cool ? cool_req : heat_req)) begin m_phase = M_POST; m_el = 1; end
          else if (m_el == PRE_CYC) begin m_phase = M_RUN; m_el = 1; end
          else m_el++;
        end
        M_RUN: begin
          if (m_el >= MIN_ON && (m_cool ? (!cool_req || heat_req) : (!heat_req || cool_req))) begin
            m_phase = M_POST; m_el = 1;
          end else if (m_el < MIN_ON) m_el++;
        end
        M_POST: begin
          if (m_el == POST_CYC) begin
            m_phase = m_cool ? M_LOCK : M_IDLE; m_el = 1;
          end else m_el++;
        end
        default: begin
          if (m_el == LOCKOUT) begin m_phase = M_IDLE; m_el = 0; end
          else m_el++;
        end
      endcase
    end
    if (m_valid) begin
      check("state", state, m_code(m_phase, m_cool));
      check("fan", fan, (m_phase == M_PRE || m_phase == M_RUN || m_phase == M_POST));
      check("heater_en", heater_en, (m_phase == M_RUN && !m_cool));
      check("compressor_en", compressor_en, (m_phase == M_RUN && m_cool));
      check("conflict", conflict, m_conf);
      check("enable_overlap", heater_en & compressor_en, 0);
      check("enable_without_fan", (heater_en | compressor_en) & ~fan, 0);
    end
  end

  // Sample point: 2 time units after a rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int g = 0;
    while (state !== s && g < 200) begin
      step();
      g++;
    end
    check(name, state, s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    int g;
    int n_on;
    rst = 1'b1; heat_req = 1'b0; cool_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_state", state, 0);
    check("reset_fan", fan, 0);
    check("reset_conflict", conflict, 0);

    // 1: heat request -> fan next cycle, heater after 4 more.
    @(negedge clk); heat_req = 1'b1;
    step();
    check("t1_fan_first", fan, 1);
    check("t1_state_pre", state, 1);
    check("t1_heater_early", heater_en, 0);
    repeat (3) @(posedge clk);
    #2;
    check("t1_heater_before", heater_en, 0);
    step();
    check("t1_heater_on", heater_en, 1);
    check("t1_state_heat", state, 2);
    check("t1_comp_off", compressor_en, 0);

    // 2: drop heat 3 cycles in; minimum on-time still 16, post-run 8, no lockout.
    n = 1; g = 0;
    while (heater_en === 1'b1 && g < 100) begin
      @(negedge clk);
      if (n == 3) heat_req = 1'b0;
      step();
      if (heater_en === 1'b1) n++;
      g++;
    end
    check("t2_min_on", n, MIN_ON);
    n = 0; g = 0;
    while (fan === 1'b1 && heater_en === 1'b0 && compressor_en === 1'b0 && g < 100) begin
      n++;
      step();
      g++;
    end
    check("t2_post_len", n, POST_CYC);
    check("t2_idle", state, 0);
    step();
    check("t2_no_lock", state, 0);

    // 4: both requests in IDLE -> conflict pulses, nothing enabled.
    @(negedge clk); heat_req = 1'b1; cool_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_conflict", conflict, 1);
      check("t4_state", state, 0);
      check("t4_fan", fan, 0);
    end
    @(negedge clk); heat_req = 1'b0; cool_req = 1'b0;
    step();
    check("t4_conflict_clear", conflict, 0);

    // 3: cooling run, post-run, 32-cycle lockout with re-request mid-lock.
    @(negedge clk); cool_req = 1'b1;
    repeat (40) @(negedge clk);
    cool_req = 1'b0;
    wait_state(3'd4, "t3_reach_post");
    wait_state(3'd5, "t3_reach_lock");
    n = 0; n_on = 0; g = 0;
    while (state === 3'd5 && g < 100) begin
      n++;
      if (fan || heater_en || compressor_en) n_on++;
      @(negedge clk);
      if (n == 10) cool_req = 1'b1;
      step();
      g++;
    end
    check("t3_lock_len", n, LOCKOUT);
    check("t3_lock_all_off", n_on, 0);
    check("t3_idle_after_lock", state, 0);
    check("t3_fan_idle", fan, 0);
    step();
    check("t3_pre_after_lock", state, 1);
    check("t3_fan_pre", fan, 1);

    // 5: reset while cooling -> immediate all-off, no lockout on next request.
    wait_state(3'd3, "t5_reach_cool");
    @(negedge clk); rst = 1'b1;
    step();
    check("t5_state", state, 0);
    check("t5_fan", fan, 0);
    check("t5_heater", heater_en, 0);
    check("t5_comp", compressor_en, 0);
    @(negedge clk); rst = 1'b0; cool_req = 1'b0; heat_req = 1'b1;
    step();
    check("t5_pre_now", state, 1);
    check("t5_fan_now", fan, 1);

    // 6: heat -> cool changeover after min-on.
    wait_state(3'd2, "t6_reach_heat");
    repeat (20) @(posedge clk);
    @(negedge clk); heat_req = 1'b0; cool_req = 1'b1;
    step();
    check("t6_post", state, 4);
    check("t6_heater_off", heater_en, 0);
    check("t6_fan_post", fan, 1);
    n = 1; g = 0;
    while (state === 3'd4 && g < 100) begin
      step();
      if (state === 3'd4) n++;
      g++;
    end
    check("t6_post_len", n, POST_CYC);
    check("t6_idle", state, 0);
    step();
    check("t6_pre", state, 1);
    repeat (3) @(posedge clk);
    #2;
    check("t6_pre_end", state, 1);
    step();
    check("t6_cool", state, 3);
    check("t6_comp_on", compressor_en, 1);
    check("t6_heater_stay_off", heater_en, 0);

    // Let the cooling run finish through post-run and lockout under the model.
    @(negedge clk); cool_req = 1'b0;
    repeat (70) @(negedge clk);
    check("final_idle", state, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
